mat_mult_engine: RTL and testbench

Parametrised N×N signed matrix-multiply engine computing C = A·B from two external synchronous-read element RAMs into an external result RAM. It is the generalised successor of the fixed-size matrix-multiply top level. It integrates address generation, a pipelined MAC with back-to-back element processing, the write strobe, a start/busy/done handshake and a saturating cycle counter. It sits between the A/B operand RAMs and the C result RAM, driven by a host `start` pulse.

---
 rtl/mat_mult_pkg.sv | 36 +++
 rtl/mac_unit.sv | 55 +++++
 rtl/mat_mult_engine.sv | 177 +++++++++++++++++
 tb/tb_mat_mult_engine.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_mult_pkg.sv
// ============================================================================
// Module      : mat_mult_pkg
// Description : Shared types and helpers for the N x N matrix-multiply engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mat_mult_pkg;

  // Engine control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Tag address field is sized for the largest supported matrix (N*N <= 2^16)
  localparam int TAG_ADDR_W = 16;

  // Per-beat sideband travelling alongside the operand reads
  typedef struct packed {
    logic                  valid;
    logic                  first;
    logic                  last;
    logic [TAG_ADDR_W-1:0] c_addr;
  } tag_t;

  // Address width for an n x n row-major array
  function automatic int addr_width(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_unit.sv
// ============================================================================
// Module      : mac_unit
// Description : Signed DW x DW multiply with load/accumulate select. The
//               accumulator is registered; sum presents the value it is
//               about to take so a final result can be captured without
//               waiting a cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_unit #(
  parameter int DW = 8,
  parameter int AW = 2 * DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          en,
  input  logic          load,
  output logic [AW-1:0] sum
);

  logic signed [2*DW-1:0] a_ext;
  logic signed [2*DW-1:0] b_ext;
  logic signed [2*DW-1:0] prod;
  logic        [AW-1:0]   prod_ext;
  logic        [AW-1:0]   acc;

  assign a_ext = {{DW{a[DW-1]}}, a};
  assign b_ext = {{DW{b[DW-1]}}, b};
  assign prod  = a_ext * b_ext;

  // Sign-extend the full-precision product to accumulator width
  if (AW > 2 * DW) begin : g_ext
    assign prod_ext = {{(AW - 2 * DW){prod[2*DW-1]}}, prod};
  end else begin : g_noext
    assign prod_ext = prod[AW-1:0];
  end

  // A first beat restarts the dot product instead of adding to the old one
  assign sum = (load ? '0 : acc) + prod_ext;

  // Accumulator register, updated only on valid beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mat_mult_engine.sv
// ============================================================================
// Module      : mat_mult_engine
// Description : N x N signed matrix multiply C = A*B streaming from two
//               synchronous-read operand RAMs into a result RAM. One
//               (i,j,k) read per cycle, k fastest; one C write per element.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mat_mult_engine
  import mat_mult_pkg::*;
#(
  parameter  int N   = 8,
  parameter  int DW  = 8,
  parameter  int AW  = 2 * DW + $clog2(N),
  parameter  int CW  = 11,
  localparam int ADW = addr_width(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [DW-1:0]  a_rdata,
  input  logic [DW-1:0]  b_rdata,
  output logic [ADW-1:0] a_addr,
  output logic [ADW-1:0] b_addr,
  output logic [ADW-1:0] c_addr,
  output logic [AW-1:0]  c_wdata,
  output logic           c_we,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  clock_count
);

  localparam int KW = $clog2(N);

  state_t          state;
  logic            drain_second;
  logic [KW-1:0]   i_cnt;
  logic [KW-1:0]   j_cnt;
  logic [KW-1:0]   k_cnt;
  logic [ADW-1:0]  elem_addr;
  tag_t            issue_tag;
  tag_t            read_tag;
  logic [AW-1:0]   mac_sum;

  logic k_wrap;
  logic j_wrap;
  logic i_wrap;
  logic last_beat;
  logic accept;

  assign k_wrap    = (k_cnt == KW'(N - 1));
  assign j_wrap    = (j_cnt == KW'(N - 1));
  assign i_wrap    = (i_cnt == KW'(N - 1));
  assign last_beat = k_wrap && j_wrap && i_wrap;
  assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));

  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  // Control FSM and issue stage: addresses are stepped incrementally so no
  // multiplier is needed to form i*N+k / k*N+j.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      drain_second <= 1'b0;
      i_cnt        <= '0;
      j_cnt        <= '0;
      k_cnt        <= '0;
      a_addr       <= '0;
      b_addr       <= '0;
      elem_addr    <= '0;
      issue_tag    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state        <= ST_RUN;
            drain_second <= 1'b0;
            i_cnt        <= '0;
            j_cnt        <= '0;
            k_cnt        <= '0;
            a_addr       <= '0;
            b_addr       <= '0;
            elem_addr    <= '0;
            issue_tag    <= '{valid: 1'b1, first: 1'b1, last: 1'b0, c_addr: '0};
          end
        end
        ST_RUN: begin
          if (last_beat) begin
            state           <= ST_DRAIN;
            issue_tag.valid <= 1'b0;
          end else if (!k_wrap) begin
            k_cnt     <= k_cnt + KW'(1);
            a_addr    <= a_addr + ADW'(1);
            b_addr    <= b_addr + ADW'(N);
            issue_tag <= '{valid: 1'b1, first: 1'b0,
                           last: ((k_cnt + KW'(1)) == KW'(N - 1)),
                           c_addr: TAG_ADDR_W'(elem_addr)};
          end else if (!j_wrap) begin
            // Next column of the same row of C: rewind A to the row start
            k_cnt     <= '0;
            j_cnt     <= j_cnt + KW'(1);
            a_addr    <= a_addr - ADW'(N - 1);
            b_addr    <= ADW'(j_cnt) + ADW'(1);
            elem_addr <= elem_addr + ADW'(1);
            issue_tag <= '{valid: 1'b1, first: 1'b1, last: 1'b0,
                           c_addr: TAG_ADDR_W'(elem_addr + ADW'(1))};
          end else begin
            // Next row of C: A continues linearly, B restarts at column 0
            k_cnt     <= '0;
            j_cnt     <= '0;
            i_cnt     <= i_cnt + KW'(1);
            a_addr    <= a_addr + ADW'(1);
            b_addr    <= '0;
            elem_addr <= elem_addr + ADW'(1);
            issue_tag <= '{valid: 1'b1, first: 1'b1, last: 1'b0,
                           c_addr: TAG_ADDR_W'(elem_addr + ADW'(1))};
          end
        end
        ST_DRAIN: begin
          // Two cycles: one for the RAM read, one for the final MAC beat
          drain_second <= 1'b1;
          if (drain_second) begin
            state        <= ST_DONE;
            drain_second <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag follows the RAM read latency; completed sums go to the C port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_tag <= '0;
      c_we     <= 1'b0;
      c_wdata  <= '0;
      c_addr   <= '0;
    end else begin
      read_tag <= issue_tag;
      c_we     <= read_tag.valid && read_tag.last;
      if (read_tag.valid && read_tag.last) begin
        c_wdata <= mac_sum;
        c_addr  <= ADW'(read_tag.c_addr);
      end
    end
  end

  // Busy-cycle counter, cleared on an accepted start, saturating, held after
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clock_count <= '0;
    end else if (accept) begin
      clock_count <= '0;
    end else if (busy && (clock_count != {CW{1'b1}})) begin
      clock_count <= clock_count + CW'(1);
    end
  end

  mac_unit #(
    .DW (DW),
    .AW (AW)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .a     (a_rdata),
    .b     (b_rdata),
    .en    (read_tag.valid),
    .load  (read_tag.first),
    .sum   (mac_sum)
  );

endmodule

`default_nettype wire

// File: tb/tb_mat_mult_engine.sv
// ============================================================================
// Module      : tb_mat_mult_engine
// Description : Directed bench for mat_mult_engine: a 2x2 instance and a 4x4
//               instance with a 4-bit cycle counter, each with RAM models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mat_mult_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- N=2 instance ----------------
  logic        rst2, start2;
  logic [7:0]  a_rd2, b_rd2;
  logic [1:0]  a_ad2, b_ad2, c_ad2;
  logic [16:0] c_wd2;
  logic        c_we2, busy2, done2;
  logic [10:0] cc2;
  logic [7:0]  a_mem2 [4];
  logic [7:0]  b_mem2 [4];

  mat_mult_engine #(.N(2)) dut2 (
    .clk(clk), .reset(rst2), .start(start2),
    .a_rdata(a_rd2), .b_rdata(b_rd2),
    .a_addr(a_ad2), .b_addr(b_ad2), .c_addr(c_ad2),
    .c_wdata(c_wd2), .c_we(c_we2), .busy(busy2), .done(done2),
    .clock_count(cc2)
  );

  always @(posedge clk) begin
    a_rd2 <= a_mem2[a_ad2];
    b_rd2 <= b_mem2[b_ad2];
  end

  int          w2_addr [$];
  logic [16:0] w2_data [$];
  int          w2_cyc  [$];
  int          t0_2 = 0;

  always @(negedge clk) begin
    if (c_we2 === 1'b1) begin
      w2_addr.push_back(int'(c_ad2));
      w2_data.push_back(c_wd2);
      w2_cyc.push_back(cyc - t0_2);
    end
  end

  // ---------------- N=4, CW=4 instance ----------------
  logic        rst4, start4;
  logic [7:0]  a_rd4, b_rd4;
  logic [3:0]  a_ad4, b_ad4, c_ad4;
  logic [17:0] c_wd4;
  logic        c_we4, busy4, done4;
  logic [3:0]  cc4;
  logic [7:0]  a_mem4 [16];
  logic [7:0]  b_mem4 [16];

  mat_mult_engine #(.N(4), .CW(4)) dut4 (
    .clk(clk), .reset(rst4), .start(start4),
    .a_rdata(a_rd4), .b_rdata(b_rd4),
    .a_addr(a_ad4), .b_addr(b_ad4), .c_addr(c_ad4),
    .c_wdata(c_wd4), .c_we(c_we4), .busy(busy4), .done(done4),
    .clock_count(cc4)
  );

  always @(posedge clk) begin
    a_rd4 <= a_mem4[a_ad4];
    b_rd4 <= b_mem4[b_ad4];
  end

  int          w4_addr [$];
  logic [17:0] w4_data [$];
  int          w4_cyc  [$];
  int          t0_4 = 0;

  always @(negedge clk) begin
    if (c_we4 === 1'b1) begin
      w4_addr.push_back(int'(c_ad4));
      w4_data.push_back(c_wd4);
      w4_cyc.push_back(cyc - t0_4);
    end
  end

  // Drive start on a falling edge; the next negedge is cycle 1
  task automatic begin_run2();
    @(negedge clk);
    w2_addr.delete(); w2_data.delete(); w2_cyc.delete();
    start2 = 1'b1;
    t0_2   = cyc;
  endtask

  task automatic load_signed2();
    a_mem2[0] = 8'd1; a_mem2[1] = 8'hFE; a_mem2[2] = 8'd3; a_mem2[3] = 8'd4;
    b_mem2[0] = 8'd5; b_mem2[1] = 8'd6;  b_mem2[2] = 8'hF9; b_mem2[3] = 8'd8;
  endtask

  task automatic test_reset();
    rst2 = 1'b1; rst4 = 1'b1; start2 = 1'b0; start4 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy2, done2, c_we2} !== 3'b000) begin errors++; $display("FAIL reset_flags2 got %b want 000", {busy2, done2, c_we2}); end
    checks++; if (cc2 !== 11'd0) begin errors++; $display("FAIL reset_count2 got %0d want 0", cc2); end
    checks++; if ({a_ad2, b_ad2, c_ad2} !== 6'd0) begin errors++; $display("FAIL reset_addr2 got %h want 0", {a_ad2, b_ad2, c_ad2}); end
    checks++; if (c_wd2 !== 17'd0) begin errors++; $display("FAIL reset_wdata2 got %h want 0", c_wd2); end
    checks++; if ({busy4, done4, c_we4} !== 3'b000) begin errors++; $display("FAIL reset_flags4 got %b want 000", {busy4, done4, c_we4}); end
    checks++; if (cc4 !== 4'd0) begin errors++; $display("FAIL reset_count4 got %0d want 0", cc4); end
    rst2 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity_n2();
    int exp_data [4] = '{1, 2, 3, 4};
    int exp_cyc  [4] = '{4, 6, 8, 10};
    a_mem2[0] = 8'd1; a_mem2[1] = 8'd2; a_mem2[2] = 8'd3; a_mem2[3] = 8'd4;
    b_mem2[0] = 8'd1; b_mem2[1] = 8'd0; b_mem2[2] = 8'd0; b_mem2[3] = 8'd1;
    begin_run2();
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1) start2 = 1'b0;
      checks++; if (busy2 !== (c <= 10)) begin errors++; $display("FAIL id_busy c%0d got %b want %b", c, busy2, (c <= 10)); end
      checks++; if (done2 !== (c >= 11)) begin errors++; $display("FAIL id_done c%0d got %b want %b", c, done2, (c >= 11)); end
      checks++; if (c_we2 !== (c == 4 || c == 6 || c == 8 || c == 10)) begin errors++; $display("FAIL id_we c%0d got %b", c, c_we2); end
      if (c == 1) begin checks++; if ({a_ad2, b_ad2} !== 4'b0000) begin errors++; $display("FAIL id_addr_beat0 got a=%0d b=%0d want 0 0", a_ad2, b_ad2); end end
      if (c == 2) begin checks++; if ({a_ad2, b_ad2} !== 4'b0110) begin errors++; $display("FAIL id_addr_beat1 got a=%0d b=%0d want 1 2", a_ad2, b_ad2); end end
      if (c == 3) begin checks++; if ({a_ad2, b_ad2} !== 4'b0001) begin errors++; $display("FAIL id_addr_beat2 got a=%0d b=%0d want 0 1", a_ad2, b_ad2); end end
      if (c == 11) begin checks++; if (cc2 !== 11'd10) begin errors++; $display("FAIL id_count got %0d want 10", cc2); end end
    end
    checks++; if (w2_data.size() != 4) begin errors++; $display("FAIL id_nwrites got %0d want 4", w2_data.size()); end
    for (int e = 0; e < 4; e++) begin
      if (e < w2_data.size()) begin
        checks++; if ($signed(w2_data[e]) !== exp_data[e] || w2_addr[e] != e || w2_cyc[e] != exp_cyc[e]) begin
          errors++; $display("FAIL id_write%0d got addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                             e, w2_addr[e], $signed(w2_data[e]), w2_cyc[e], e, exp_data[e], exp_cyc[e]);
        end
      end
    end
  endtask

  task automatic test_signed_n2();
    int exp_data [4] = '{19, -10, -13, 50};
    int exp_cyc  [4] = '{4, 6, 8, 10};
    load_signed2();
    begin_run2();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start2 = 1'b0;
      if (c == 1) begin checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL sg_done_clear got %b want 0", done2); end end
      if (c == 11) begin checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL sg_done got %b want 1", done2); end end
    end
    checks++; if (w2_data.size() != 4) begin errors++; $display("FAIL sg_nwrites got %0d want 4", w2_data.size()); end
    for (int e = 0; e < 4; e++) begin
      if (e < w2_data.size()) begin
        checks++; if ($signed(w2_data[e]) !== exp_data[e] || w2_addr[e] != e || w2_cyc[e] != exp_cyc[e]) begin
          errors++; $display("FAIL sg_write%0d got addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                             e, w2_addr[e], $signed(w2_data[e]), w2_cyc[e], e, exp_data[e], exp_cyc[e]);
        end
      end
    end
  endtask

  task automatic test_start_ignored_n2();
    int exp_data [4] = '{19, -10, -13, 50};
    load_signed2();
    begin_run2();
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start2 = (c <= 10) && (c % 2 == 0);
      if (c == 11) begin
        checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL spam_done got %b want 1", done2); end
        checks++; if (cc2 !== 11'd10) begin errors++; $display("FAIL spam_count got %0d want 10", cc2); end
      end
    end
    checks++; if (w2_data.size() != 4) begin errors++; $display("FAIL spam_nwrites got %0d want 4", w2_data.size()); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL spam_busy got %b want 0", busy2); end
    for (int e = 0; e < 4; e++) begin
      if (e < w2_data.size()) begin
        checks++; if ($signed(w2_data[e]) !== exp_data[e] || w2_addr[e] != e) begin
          errors++; $display("FAIL spam_write%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                             e, w2_addr[e], $signed(w2_data[e]), e, exp_data[e]);
        end
      end
    end
  endtask

  task automatic test_reset_midrun_n2();
    int exp_data [4] = '{19, -10, -13, 50};
    load_signed2();
    begin_run2();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) start2 = 1'b0;
    end
    // cycle 6 carries the second write; reset lands before the next edge
    rst2 = 1'b1;
    #1;
    checks++; if ({busy2, done2, c_we2} !== 3'b000) begin errors++; $display("FAIL rst_async_flags got %b want 000", {busy2, done2, c_we2}); end
    checks++; if (cc2 !== 11'd0) begin errors++; $display("FAIL rst_async_count got %0d want 0", cc2); end
    @(posedge clk);
    w2_addr.delete(); w2_data.delete(); w2_cyc.delete();
    repeat (3) @(negedge clk);
    checks++; if (w2_data.size() != 0) begin errors++; $display("FAIL rst_no_writes got %0d want 0", w2_data.size()); end
    rst2 = 1'b0;
    begin_run2();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start2 = 1'b0;
      if (c == 11) begin checks++; if (cc2 !== 11'd10) begin errors++; $display("FAIL rst_rerun_count got %0d want 10", cc2); end end
    end
    checks++; if (w2_data.size() != 4) begin errors++; $display("FAIL rst_rerun_nwrites got %0d want 4", w2_data.size()); end
    for (int e = 0; e < 4; e++) begin
      if (e < w2_data.size()) begin
        checks++; if ($signed(w2_data[e]) !== exp_data[e] || w2_addr[e] != e) begin
          errors++; $display("FAIL rst_rerun_write%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                             e, w2_addr[e], $signed(w2_data[e]), e, exp_data[e]);
        end
      end
    end
  endtask

  task automatic test_n4_saturate_back_to_back();
    for (int x = 0; x < 16; x++) begin a_mem4[x] = 8'h80; b_mem4[x] = 8'h80; end
    @(negedge clk);
    w4_addr.delete(); w4_data.delete(); w4_cyc.delete();
    start4 = 1'b1;
    t0_4   = cyc;
    for (int c = 1; c <= 67; c++) begin
      @(negedge clk);
      if (c == 1) start4 = 1'b0;
      checks++; if (busy4 !== (c <= 66)) begin errors++; $display("FAIL n4_busy c%0d got %b want %b", c, busy4, (c <= 66)); end
      checks++; if (done4 !== (c >= 67)) begin errors++; $display("FAIL n4_done c%0d got %b want %b", c, done4, (c >= 67)); end
      checks++; if (c_we4 !== (c >= 6 && (c - 2) % 4 == 0)) begin errors++; $display("FAIL n4_we c%0d got %b", c, c_we4); end
      if (c == 10) begin checks++; if (cc4 !== 4'd9) begin errors++; $display("FAIL n4_count10 got %0d want 9", cc4); end end
      if (c == 16) begin checks++; if (cc4 !== 4'd15) begin errors++; $display("FAIL n4_count16 got %0d want 15", cc4); end end
      if (c == 67) begin checks++; if (cc4 !== 4'd15) begin errors++; $display("FAIL n4_count_sat got %0d want 15", cc4); end end
    end
    checks++; if (w4_data.size() != 16) begin errors++; $display("FAIL n4_nwrites got %0d want 16", w4_data.size()); end
    for (int e = 0; e < 16; e++) begin
      if (e < w4_data.size()) begin
        checks++; if (w4_data[e] !== 18'd65536 || w4_addr[e] != e || w4_cyc[e] != (e + 1) * 4 + 2) begin
          errors++; $display("FAIL n4_write%0d got addr=%0d data=%0d cyc=%0d want addr=%0d data=65536 cyc=%0d",
                             e, w4_addr[e], w4_data[e], w4_cyc[e], e, (e + 1) * 4 + 2);
        end
      end
    end
    // Restart on the first cycle done is visible
    w4_addr.delete(); w4_data.delete(); w4_cyc.delete();
    start4 = 1'b1;
    t0_4   = cyc;
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start4 = 1'b0;
        checks++; if ({done4, busy4} !== 2'b01) begin errors++; $display("FAIL b2b_restart got done=%b busy=%b want 0 1", done4, busy4); end
        checks++; if (cc4 !== 4'd0) begin errors++; $display("FAIL b2b_count_clear got %0d want 0", cc4); end
      end
      if (c == 66) begin checks++; if ({done4, busy4} !== 2'b01) begin errors++; $display("FAIL b2b_c66 got done=%b busy=%b want 0 1", done4, busy4); end end
      if (c == 67) begin checks++; if ({done4, busy4} !== 2'b10) begin errors++; $display("FAIL b2b_c67 got done=%b busy=%b want 1 0", done4, busy4); end end
    end
    checks++; if (w4_data.size() != 16) begin errors++; $display("FAIL b2b_nwrites got %0d want 16", w4_data.size()); end
    for (int e = 0; e < 16; e++) begin
      if (e < w4_data.size()) begin
        checks++; if (w4_data[e] !== 18'd65536 || w4_addr[e] != e) begin
          errors++; $display("FAIL b2b_write%0d got addr=%0d data=%0d want addr=%0d data=65536",
                             e, w4_addr[e], w4_data[e], e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity_n2();
    test_signed_n2();
    test_start_ignored_n2();
    test_reset_midrun_n2();
    test_n4_saturate_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
